// File: rtl/dcmac_reset_sequencer.sv
// rtl/dcmac_reset_sequencer.sv - DCMAC GT/core reset handshake initiator with timeout retry and lock supervision
module dcmac_reset_sequencer #(
    parameter int GT_RST_CYCLES    = 64,
    parameter int TIMEOUT_CYCLES   = 1000000,
    parameter int CORE_HOLD_CYCLES = 16,
    parameter int MAX_RETRIES      = 3,
    parameter int SYNC_STAGES      = 3,
    parameter int CNT_W            = 24
) (
    input  logic       clk,
    input  logic       resetn_async_inv,
    input  logic       soft_reset_req,
    input  logic       gt_reset_done,
    output logic       gt_reset,
    output logic       core_resetn,
    output logic       seq_done,
    output logic       seq_fault,
    output logic [3:0] retry_count
);

    typedef enum logic [2:0] {
        ASSERT_GT,
        WAIT_GT,
        HOLD_CORE,
        RUNNING,
        FAULT
    } state_t;

    localparam logic [CNT_W-1:0] GT_LAST      = CNT_W'(GT_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(CORE_HOLD_CYCLES - 1);
    localparam logic [4:0]       RETRY_LIMIT  = 5'(MAX_RETRIES);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [3:0]       retry_nxt;
    logic             gt_done_s;

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;

    assign gt_done_s = sync_q[SYNC_STAGES-1];

    // Bring the GT's reset-done flag into the clk domain through a flop chain
    always_ff @(posedge clk or negedge resetn_async_inv) begin
        if (!resetn_async_inv) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], gt_reset_done};
        end
    end

    // Next-state decision; the shared counter clears whenever a state is (re)entered
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + CNT_W'(1);
        retry_nxt = retry_count;
        if (soft_reset_req) begin
            state_nxt = ASSERT_GT;
            cnt_nxt   = '0;
            retry_nxt = '0;
        end else begin
            case (state)
                ASSERT_GT: begin
                    if (cnt == GT_LAST) begin
                        state_nxt = WAIT_GT;
                        cnt_nxt   = '0;
                    end
                end
                WAIT_GT: begin
                    // Success is tested first so a late lock on the timeout cycle still wins
                    if (gt_done_s) begin
                        state_nxt = HOLD_CORE;
                        cnt_nxt   = '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        cnt_nxt   = '0;
                        retry_nxt = ({1'b0, retry_count} < RETRY_LIMIT) ? retry_count + 4'd1 : retry_count;
                        state_nxt = (({1'b0, retry_count} + 5'd1) < RETRY_LIMIT) ? ASSERT_GT : FAULT;
                    end
                end
                HOLD_CORE: begin
                    // A lock drop during the hold restarts the wait without charging a retry
                    if (!gt_done_s) begin
                        state_nxt = WAIT_GT;
                        cnt_nxt   = '0;
                    end else if (cnt == HOLD_LAST) begin
                        state_nxt = RUNNING;
                        cnt_nxt   = '0;
                    end
                end
                RUNNING: begin
                    cnt_nxt = '0;
                    if (!gt_done_s) begin
                        state_nxt = ASSERT_GT;
                        retry_nxt = '0;
                    end
                end
                FAULT: begin
                    cnt_nxt = '0;
                end
                default: begin
                    state_nxt = ASSERT_GT;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Sequencer registers; outputs are decoded from the next state so they change on the entering edge
    always_ff @(posedge clk or negedge resetn_async_inv) begin
        if (!resetn_async_inv) begin
            state       <= ASSERT_GT;
            cnt         <= '0;
            retry_count <= '0;
            gt_reset    <= 1'b1;
            core_resetn <= 1'b0;
            seq_done    <= 1'b0;
            seq_fault   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            retry_count <= retry_nxt;
            gt_reset    <= (state_nxt == ASSERT_GT) || (state_nxt == FAULT);
            core_resetn <= (state_nxt == RUNNING);
            seq_done    <= (state_nxt == RUNNING);
            seq_fault   <= (state_nxt == FAULT);
        end
    end

endmodule

// File: tb/tb_dcmac_reset_sequencer.sv
// tb/tb_dcmac_reset_sequencer.sv - scoreboard bench for dcmac_reset_sequencer
module tb_dcmac_reset_sequencer;

    localparam int GT   = 64;
    localparam int TO   = 100;
    localparam int HOLD = 16;
    localparam int MAXR = 3;
    localparam int SYNC = 3;

    logic       clk = 1'b0;
    logic       resetn_async_inv = 1'b0;
    logic       soft_reset_req = 1'b0;
    logic       gt_reset_done = 1'b1;
    logic       gt_reset;
    logic       core_resetn;
    logic       seq_done;
    logic       seq_fault;
    logic [3:0] retry_count;
    logic [7:0] obs;

    int edge_cnt = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        int         at;
        logic [7:0] vec;
    } ev_t;

    ev_t evq[$];

    dcmac_reset_sequencer #(
        .GT_RST_CYCLES   (GT),
        .TIMEOUT_CYCLES  (TO),
        .CORE_HOLD_CYCLES(HOLD),
        .MAX_RETRIES     (MAXR),
        .SYNC_STAGES     (SYNC),
        .CNT_W           (24)
    ) dut (
        .clk             (clk),
        .resetn_async_inv(resetn_async_inv),
        .soft_reset_req  (soft_reset_req),
        .gt_reset_done   (gt_reset_done),
        .gt_reset        (gt_reset),
        .core_resetn     (core_resetn),
        .seq_done        (seq_done),
        .seq_fault       (seq_fault),
        .retry_count     (retry_count)
    );

    // Observed output vector: {gt_reset, core_resetn, seq_done, seq_fault, retry_count}
    assign obs = {gt_reset, core_resetn, seq_done, seq_fault, retry_count};

    initial forever #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic expect_ev(input int at, input logic [7:0] v);
        ev_t e;
        e.at  = at;
        e.vec = v;
        evq.push_back(e);
    endtask

    task automatic go_to(input int n);
        while (edge_cnt < n) @(negedge clk);
    endtask

    // A reset-GT attempt that starts at edge a and whose GT never reports done
    task automatic failing_attempts(input int a, input int r0, input int n, output int a_next);
        int r;
        a_next = a;
        for (int i = 0; i < n; i++) begin
            r = r0 + i;
            expect_ev(a_next + GT, 8'(r));
            a_next = a_next + GT + TO;
            if (r + 1 < MAXR) expect_ev(a_next, 8'h80 | 8'(r + 1));
            else              expect_ev(a_next, 8'h90 | 8'(r + 1));
        end
    endtask

    // A reset-GT attempt that starts at edge a with GT done already high by the wait phase
    task automatic good_attempt(input int a, input int r);
        expect_ev(a + GT, 8'(r));
        expect_ev(a + GT + 1 + HOLD, 8'h60 | 8'(r));
    endtask

    // Monitor: every output change must match the head of the expected-event queue
    initial begin
        logic [7:0] prev;
        ev_t        e;
        @(negedge clk);
        prev = obs;
        forever begin
            @(negedge clk);
            if (obs !== prev) begin
                if (evq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_change: got 0x%0h at edge %0d, required no change from 0x%0h", obs, edge_cnt, prev);
                end else begin
                    e = evq.pop_front();
                    check("event_edge", edge_cnt, e.at);
                    check("event_value", int'(obs), int'(e.vec));
                end
                prev = obs;
            end
        end
    end

    // Stimulus
    initial begin
        int k, a, r, l, s, nf, h, k2, g, e;

        // Nominal power-up with GT done tied high
        go_to(3);
        check("reset_state", int'(obs), 8'h80);
        r = 3 + $urandom_range(0, 5);
        go_to(r);
        resetn_async_inv = 1'b1;
        good_attempt(r, 0);
        go_to(r + GT + 1 + HOLD + 5);

        // Loss of lock while running
        for (int i = 0; i < 2; i++) begin
            k = edge_cnt + $urandom_range(2, 30);
            go_to(k);
            gt_reset_done = 1'b0;
            expect_ev(k + SYNC + 1, 8'h80);
            good_attempt(k + SYNC + 1, 0);
            l = $urandom_range(1, 20);
            go_to(k + l);
            gt_reset_done = 1'b1;
            go_to(k + SYNC + 1 + GT + 1 + HOLD + 5);
        end

        // Soft reset held for a random number of cycles
        k = edge_cnt + $urandom_range(2, 20);
        s = $urandom_range(1, 80);
        go_to(k);
        soft_reset_req = 1'b1;
        expect_ev(k + 1, 8'h80);
        go_to(k + s);
        soft_reset_req = 1'b0;
        good_attempt(k + s, 0);
        go_to(k + s + GT + 1 + HOLD + 5);

        // Timeouts exhaust the retries and land in FAULT, which must stay put
        k = edge_cnt + $urandom_range(2, 20);
        go_to(k);
        gt_reset_done = 1'b0;
        a = k + SYNC + 1;
        expect_ev(a, 8'h80);
        failing_attempts(a, 0, MAXR, a);
        go_to(a + 1000);

        // Recovery from FAULT with a single-cycle soft reset
        k = edge_cnt + $urandom_range(1, 5);
        go_to(k);
        soft_reset_req = 1'b1;
        gt_reset_done = 1'b1;
        expect_ev(k + 1, 8'h80);
        good_attempt(k + 1, 0);
        go_to(k + 1);
        soft_reset_req = 1'b0;
        go_to(k + 1 + GT + 1 + HOLD + 5);

        // Some failed attempts, then a lock glitch in the core hold
        nf = $urandom_range(1, MAXR - 1);
        k = edge_cnt + $urandom_range(2, 20);
        go_to(k);
        gt_reset_done = 1'b0;
        a = k + SYNC + 1;
        expect_ev(a, 8'h80);
        failing_attempts(a, 0, nf, a);
        expect_ev(a + GT, 8'(nf));
        h = a + GT + 1;
        k2 = h - 3 + $urandom_range(0, HOLD - 2);
        g = $urandom_range(1, 10);
        expect_ev(k2 + g + SYNC + 1 + HOLD, 8'h60 | 8'(nf));
        go_to(a + 10);
        gt_reset_done = 1'b1;
        go_to(k2);
        gt_reset_done = 1'b0;
        go_to(k2 + g);
        gt_reset_done = 1'b1;
        go_to(k2 + g + SYNC + 1 + HOLD + 5);

        // Asynchronous reset in the middle of a wait with two retries charged
        k = edge_cnt + $urandom_range(2, 20);
        go_to(k);
        gt_reset_done = 1'b0;
        a = k + SYNC + 1;
        expect_ev(a, 8'h80);
        failing_attempts(a, 0, 2, a);
        expect_ev(a + GT, 8'd2);
        e = a + GT + $urandom_range(5, 90);
        go_to(e);
        expect_ev(e + 1, 8'h80);
        @(posedge clk);
        #2 resetn_async_inv = 1'b0;
        #1 check("async_reset_outputs", int'(obs), 8'h80);
        gt_reset_done = 1'b1;
        r = e + 1 + $urandom_range(2, 6);
        go_to(r);
        resetn_async_inv = 1'b1;
        good_attempt(r, 0);
        go_to(r + GT + 1 + HOLD + 5);

        go_to(edge_cnt + 10);
        check("pending_events", evq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
